step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
- Pattern-playback stage between the BPM tick generator and the beat synthesiser.
- Holds 4 drum maps of 32 steps × 3-bit sample codes (96 bits per map).
- On each eighth-note step tick, emits the current step's sample code with a strobe, then advances.
- Map changes from the switches are deferred to the bar boundary so a pattern never switches mid-bar.

Parameters:
- STEPS, 32, steps per map (power of two).
- STEP_W, 5, log2(STEPS).
- SAMPLE_W, 3, sample code width; code 0 = rest.
- NUM_MAPS, 4, number of stored maps.
- MAP_W, 2, log2(NUM_MAPS).

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- enable  in  1  play/run (SW[2]); level.
- step_tick  in  1  one-cycle pulse per eighth note from the BPM tick generator.
- map_sel  in  MAP_W  requested map (SW[1:0]).
- wr_en  in  1  pattern write strobe.
- wr_map  in  MAP_W  write target map.
- wr_step  in  STEP_W  write target step.
- wr_data  in  SAMPLE_W  sample code to store.
- sample_out  out  SAMPLE_W  sample code of last played step; to beat synth map_value.
- sample_valid  out  1  one-cycle strobe, high when a non-rest step plays.
- bar_start  out  1  one-cycle strobe, high when step 0 plays (rest or not).
- step_idx  out  STEP_W  index of the last played step.
- active_map  out  MAP_W  map currently playing.

Behaviour:
- Reset and clocking:
  - Reset is asynchronous on nrst low, active-low; all logic clocks on the rising edge of clk.
  - Reset values: sample_out=0, sample_valid=0, bar_start=0, step_idx=0, active_map=0, ptr=0, state=IDLE, pending_map=0.
  - All pattern memory cells are cleared to 0 on reset (register array, NUM_MAPS×STEPS×SAMPLE_W flops).
- Internal state: ptr (STEP_W, next step to play) and state ∈ {IDLE, RUN}.
- IDLE:
  - step_tick is ignored; outputs hold their reset/cleared values.
  - When enable=1, go to RUN with ptr=0 and active_map=map_sel sampled that cycle.
  - A step_tick in that same cycle is ignored; the first played step is on the next tick.
- RUN:
  - If enable=0, go to IDLE in 1 cycle: ptr=0, sample_out=0, step_idx=0, strobes=0. active_map holds. Any in-flight tick is discarded.
  - On step_tick=1, in the next cycle (latency 1):
    - sample_out = mem[active_map][ptr], step_idx = ptr.
    - sample_valid = (code ≠ 0).
    - bar_start = (ptr == 0).
    - ptr = ptr+1 mod STEPS (wraps 31→0).
  - sample_valid and bar_start are single-cycle and deassert the following cycle. sample_out/step_idx hold until the next played step.
- Map switching:
  - pending_map registers map_sel every cycle.
  - On a tick that plays step STEPS-1, active_map takes pending_map in the same update, so step 0 of the next bar uses the new map.
  - A map_sel change and back within one bar produces no switch.
- Write port:
  - wr_en=1 writes wr_data to mem[wr_map][wr_step] at the clock edge. Writes are legal in any state.
  - A write and a tick that reads the same cell in the same cycle: the play reads the OLD value; the new value is heard on the next pass.
  - Writes to a non-active map never disturb playback.
- Back-to-back ticks on consecutive cycles are legal: each produces one play, no drops.
- Reset mid-bar: all state and memory return to reset values immediately. Playback restarts from step 0 on the next enable rise or tick per the rules above.

Test Plan:
- Reset then write map 0 steps 0..3 = 1,0,5,7; enable=1, 4 ticks spaced 10 cycles → sample_out 1,0,5,7 one cycle after each tick; sample_valid 1,0,1,1; bar_start only on first; step_idx 0..3.
- Enable rises in same cycle as tick → no output; next tick plays step 0 with bar_start=1.
- Playing map 0, set map_sel=2 at step 10 → steps 11..31 still from map 0; 33rd tick plays map 2 step 0 (preloaded 6) with active_map=2 and bar_start=1.
- wr_en to map 0 step 5 (data 4) in same cycle as tick playing step 5 (old 2) → output 2; after 32 more ticks step 5 outputs 4.
- 40 consecutive-cycle ticks → 40 plays, step_idx wraps 31→0, bar_start pulses at plays 1 and 33.
- enable=0 at step 17 → next cycle sample_out=0, step_idx=0; re-enable plus tick → step 0 plays. nrst pulse mid-bar → all outputs 0 and memory cleared (step 0 plays rest).

Source files
------------

// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
// Pattern-playback stage between the BPM tick generator and the beat
// synthesiser. Stores NUM_MAPS drum maps of STEPS sample codes each and, while
// running, plays one step per step_tick (one cycle of latency), then advances.
// A requested map change only takes effect at the bar boundary, so a pattern
// never switches part-way through a bar.
//
// Ports:
//   clk          system clock (rising edge)
//   nrst         asynchronous active-low reset
//   enable       play/run level
//   step_tick    one-cycle pulse per eighth note
//   map_sel      requested map
//   wr_en        pattern write strobe
//   wr_map       write target map
//   wr_step      write target step
//   wr_data      sample code to store
//   sample_out   sample code of the last played step
//   sample_valid one-cycle strobe when a non-rest step plays
//   bar_start    one-cycle strobe when step 0 plays
//   step_idx     index of the last played step
//   active_map   map currently playing
// -----------------------------------------------------------------------------
module step_sequencer #(
   parameter int STEPS    = 32,
   parameter int STEP_W   = 5,
   parameter int SAMPLE_W = 3,
   parameter int NUM_MAPS = 4,
   parameter int MAP_W    = 2
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                enable,
   input  logic                step_tick,
   input  logic [MAP_W-1:0]    map_sel,
   input  logic                wr_en,
   input  logic [MAP_W-1:0]    wr_map,
   input  logic [STEP_W-1:0]   wr_step,
   input  logic [SAMPLE_W-1:0] wr_data,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   output logic                bar_start,
   output logic [STEP_W-1:0]   step_idx,
   output logic [MAP_W-1:0]    active_map
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   state_t                state_r;
   state_t                state_s;
   logic [STEP_W-1:0]     ptr_r;
   logic [STEP_W-1:0]     ptr_s;
   logic [MAP_W-1:0]      pending_map_r;
   logic [MAP_W-1:0]      active_map_s;
   logic [SAMPLE_W-1:0]   sample_out_s;
   logic                  sample_valid_s;
   logic                  bar_start_s;
   logic [STEP_W-1:0]     step_idx_s;
   logic [SAMPLE_W-1:0]   rd_code_s;

   // Flat pattern store, addressed as {map, step}.
   logic [SAMPLE_W-1:0]   mem_r [NUM_MAPS*STEPS];

   // Read of the cell about to be played; sees the pre-edge contents, so a
   // write to the same cell in the same cycle is only heard on the next pass.
   assign rd_code_s = mem_r[{active_map, ptr_r}];

   // Pattern memory: cleared on reset, one write per cycle from the write port.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NUM_MAPS*STEPS; i++) begin
            mem_r[i] <= {SAMPLE_W{1'b0}};
         end
      end else if (wr_en) begin
         mem_r[{wr_map, wr_step}] <= wr_data;
      end
   end

   // State, pointer, pending map and registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r       <= IDLE;
         ptr_r         <= {STEP_W{1'b0}};
         pending_map_r <= {MAP_W{1'b0}};
         active_map    <= {MAP_W{1'b0}};
         sample_out    <= {SAMPLE_W{1'b0}};
         sample_valid  <= 1'b0;
         bar_start     <= 1'b0;
         step_idx      <= {STEP_W{1'b0}};
      end else begin
         state_r       <= state_s;
         ptr_r         <= ptr_s;
         pending_map_r <= map_sel;
         active_map    <= active_map_s;
         sample_out    <= sample_out_s;
         sample_valid  <= sample_valid_s;
         bar_start     <= bar_start_s;
         step_idx      <= step_idx_s;
      end
   end

   // Next-state and next-output logic; strobes default low so they last one cycle.
   always_comb begin
      state_s        = state_r;
      ptr_s          = ptr_r;
      active_map_s   = active_map;
      sample_out_s   = sample_out;
      step_idx_s     = step_idx;
      sample_valid_s = 1'b0;
      bar_start_s    = 1'b0;
      case (state_r)
         IDLE: begin
            // A tick in the start cycle is deliberately not played.
            if (enable) begin
               state_s      = RUN;
               ptr_s        = {STEP_W{1'b0}};
               active_map_s = map_sel;
            end else begin
               state_s      = IDLE;
            end
         end
         RUN: begin
            if (!enable) begin
               state_s      = IDLE;
               ptr_s        = {STEP_W{1'b0}};
               sample_out_s = {SAMPLE_W{1'b0}};
               step_idx_s   = {STEP_W{1'b0}};
            end else if (step_tick) begin
               sample_out_s   = rd_code_s;
               step_idx_s     = ptr_r;
               sample_valid_s = (rd_code_s != {SAMPLE_W{1'b0}});
               bar_start_s    = (ptr_r == {STEP_W{1'b0}});
               ptr_s          = ptr_r + STEP_W'(1);
               // Swap maps together with the last step so the next bar's step 0
               // already comes from the newly requested map.
               if (ptr_r == LAST_STEP) begin
                  active_map_s = pending_map_r;
               end else begin
                  active_map_s = active_map;
               end
            end else begin
               state_s = RUN;
            end
         end
         default: begin
            state_s = IDLE;
            ptr_s   = {STEP_W{1'b0}};
         end
      endcase
   end

endmodule

// File: tb/tb_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer
// Directed and randomized bench for step_sequencer. A behavioural model
// (array of maps, a play pointer, a running flag) predicts every output after
// each clock edge; directed steps additionally pin down known values.
// -----------------------------------------------------------------------------
module tb_step_sequencer;

   logic       clk;
   logic       nrst;
   logic       enable;
   logic       step_tick;
   logic [1:0] map_sel;
   logic       wr_en;
   logic [1:0] wr_map;
   logic [4:0] wr_step;
   logic [2:0] wr_data;
   logic [2:0] sample_out;
   logic       sample_valid;
   logic       bar_start;
   logic [4:0] step_idx;
   logic [1:0] active_map;

   int n_cmp = 0;
   int n_err = 0;

   // reference model
   int m_mem [4][32];
   int m_run, m_ptr, m_amap, m_pend;
   int e_sample, e_idx, e_valid, e_bar;

   step_sequencer dut (
      .clk          (clk),
      .nrst         (nrst),
      .enable       (enable),
      .step_tick    (step_tick),
      .map_sel      (map_sel),
      .wr_en        (wr_en),
      .wr_map       (wr_map),
      .wr_step      (wr_step),
      .wr_data      (wr_data),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .bar_start    (bar_start),
      .step_idx     (step_idx),
      .active_map   (active_map)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 4; m++)
         for (int s = 0; s < 32; s++)
            m_mem[m][s] = 0;
      m_run = 0; m_ptr = 0; m_amap = 0; m_pend = 0;
      e_sample = 0; e_idx = 0; e_valid = 0; e_bar = 0;
   endtask

   // One clock edge of behaviour, from the current input values.
   task automatic model_step();
      int code;
      e_valid = 0;
      e_bar   = 0;
      if (m_run == 0) begin
         if (enable) begin
            m_run  = 1;
            m_ptr  = 0;
            m_amap = int'(map_sel);
         end
      end else if (!enable) begin
         m_run    = 0;
         m_ptr    = 0;
         e_sample = 0;
         e_idx    = 0;
      end else if (step_tick) begin
         code     = m_mem[m_amap][m_ptr];
         e_sample = code;
         e_idx    = m_ptr;
         e_valid  = (code != 0) ? 1 : 0;
         e_bar    = (m_ptr == 0) ? 1 : 0;
         if (m_ptr == 31) m_amap = m_pend;
         m_ptr    = (m_ptr + 1) % 32;
      end
      m_pend = int'(map_sel);
      if (wr_en) m_mem[int'(wr_map)][int'(wr_step)] = int'(wr_data);
   endtask

   task automatic check_all();
      check("sample_out",   32'(sample_out),   e_sample);
      check("sample_valid", 32'(sample_valid), e_valid);
      check("bar_start",    32'(bar_start),    e_bar);
      check("step_idx",     32'(step_idx),     e_idx);
      check("active_map",   32'(active_map),   m_amap);
   endtask

   // Apply one cycle of stimulus, clock it, compare against the model.
   task automatic cyc(input logic tk, input logic we, input int wm, input int ws, input int wd);
      step_tick = tk;
      wr_en     = we;
      wr_map    = 2'(wm);
      wr_step   = 5'(ws);
      wr_data   = 3'(wd);
      model_step();
      @(posedge clk);
      #1;
      check_all();
      step_tick = 1'b0;
      wr_en     = 1'b0;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0, 0);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0);
   endtask

   // Asynchronous reset pulse: outputs must clear before any clock edge.
   task automatic do_reset();
      nrst = 1'b0;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      nrst = 1'b1;
   endtask

   initial begin
      nrst      = 1'b1;
      enable    = 1'b0;
      step_tick = 1'b0;
      map_sel   = 2'd0;
      wr_en     = 1'b0;
      wr_map    = 2'd0;
      wr_step   = 5'd0;
      wr_data   = 3'd0;
      model_reset();
      #2;
      do_reset();

      // Load patterns while idle.
      cyc(1'b0, 1'b1, 0, 0, 1);
      cyc(1'b0, 1'b1, 0, 1, 0);
      cyc(1'b0, 1'b1, 0, 2, 5);
      cyc(1'b0, 1'b1, 0, 3, 7);
      cyc(1'b0, 1'b1, 0, 5, 2);
      cyc(1'b0, 1'b1, 2, 0, 6);
      // Tick while idle is ignored.
      cyc(1'b1, 1'b0, 0, 0, 0);
      check("idle_tick_valid", 32'(sample_valid), 0);

      // Basic play, ticks spaced 10 cycles apart.
      enable = 1'b1;
      idle_n(1);
      begin
         int exp_code [4] = '{1, 0, 5, 7};
         for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 0, 0, 0);
            check("basic_code",  32'(sample_out),   exp_code[i]);
            check("basic_valid", 32'(sample_valid), (exp_code[i] != 0) ? 1 : 0);
            check("basic_bar",   32'(bar_start),    (i == 0) ? 1 : 0);
            check("basic_idx",   32'(step_idx),     i);
            idle_n(9);
         end
      end

      // Enable rises in the same cycle as a tick.
      enable = 1'b0;
      idle_n(1);
      enable = 1'b1;
      cyc(1'b1, 1'b0, 0, 0, 0);
      check("en_tick_valid", 32'(sample_valid), 0);
      check("en_tick_bar",   32'(bar_start),    0);
      idle_n(3);
      cyc(1'b1, 1'b0, 0, 0, 0);
      check("first_play_bar",  32'(bar_start),  1);
      check("first_play_code", 32'(sample_out), 1);

      // Map switch requested mid-bar takes effect at the bar boundary.
      tick_n(10);
      check("sw_idx10", 32'(step_idx), 10);
      map_sel = 2'd2;
      tick_n(20);
      check("sw_still_map0", 32'(active_map), 0);
      tick_n(1);
      cyc(1'b1, 1'b0, 0, 0, 0);
      check("sw_code",   32'(sample_out), 6);
      check("sw_map",    32'(active_map), 2);
      check("sw_bar",    32'(bar_start),  1);

      // Write colliding with the play of the same cell.
      map_sel = 2'd0;
      tick_n(31);
      tick_n(5);
      cyc(1'b1, 1'b1, 0, 5, 4);
      check("coll_old", 32'(sample_out), 2);
      tick_n(31);
      cyc(1'b1, 1'b0, 0, 0, 0);
      check("coll_new_idx", 32'(step_idx),   5);
      check("coll_new",     32'(sample_out), 4);

      // 40 back-to-back ticks from a bar boundary.
      tick_n(26);
      begin
         int bars = 0;
         for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 0, 0, 0);
            if (bar_start) bars++;
            check("b2b_idx", 32'(step_idx),  i % 32);
            check("b2b_bar", 32'(bar_start), (i == 0 || i == 32) ? 1 : 0);
         end
         check("b2b_bar_count", bars, 2);
      end

      // Disable mid-bar, then re-enable.
      tick_n(10);
      check("dis_idx17", 32'(step_idx), 17);
      enable = 1'b0;
      idle_n(1);
      check("dis_code", 32'(sample_out), 0);
      check("dis_idx",  32'(step_idx),   0);
      enable = 1'b1;
      idle_n(1);
      cyc(1'b1, 1'b0, 0, 0, 0);
      check("reen_idx", 32'(step_idx),  0);
      check("reen_bar", 32'(bar_start), 1);

      // Reset mid-bar clears state and memory.
      tick_n(5);
      do_reset();
      check("rst_code", 32'(sample_out), 0);
      check("rst_idx",  32'(step_idx),   0);
      idle_n(1);
      cyc(1'b1, 1'b0, 0, 0, 0);
      check("rst_play_code",  32'(sample_out),   0);
      check("rst_play_valid", 32'(sample_valid), 0);
      check("rst_play_bar",   32'(bar_start),    1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 99) == 0) map_sel = 2'($urandom_range(0, 3));
         cyc(1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 31)),
             int'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
